// File: rtl/uart_serdes_pkg.sv
// Purpose: shared types and frame constants for the UART serial engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_serdes_pkg;

    // Both TX and RX engines walk the same four phases of an 8N1 frame.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } serdes_state_t;

    localparam int DIV_W     = 12;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

endpackage

// File: rtl/uart_sync_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO holding UART bytes.
// Latency: written data visible at rd_dat the cycle after push; flags are registered-state derived.
// Backpressure: push on full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
//
// Ports: uart_clock_i/uart_reset_i (sync, active-high), push/wr_dat, pop/rd_dat (0 when empty), full, empty.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             uart_clock_i,
    input  logic             uart_reset_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A pop frees the slot in the same cycle, so push-while-full succeeds when paired with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_dat = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge uart_clock_i) begin
        if (uart_reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge uart_clock_i) begin
        if (do_push) mem[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/uart_serdes_core.sv
// Purpose: 8N1 serialiser/deserialiser with TX and RX byte FIFOs behind the UART register front-end.
// Latency: push into an idle, empty TX FIFO gives the start bit two cycles later; RX byte lands in the FIFO after the mid-stop sample.
// Backpressure: TX push on full and RX bytes arriving on full are dropped; pops on empty are ignored.
//
// Ports: uart_clock_i, uart_reset_i (sync, active-high), divisor_i (bit = divisor_i+1 clocks),
//        tx_en_i/rx_en_i, tx_push_i/tx_data_i, rx_pop_i/rx_data_o (FWFT, 0 when empty),
//        tx_full_o/tx_empty_o/rx_full_o/rx_empty_o, uart_rx_i (async), uart_tx_o (registered).
// Build option UART_RX_ERR_EN adds rx_err_o = {overrun, framing} (sticky) and rx_err_clr_i.
module uart_serdes_core
    import uart_serdes_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             uart_clock_i,
    input  logic             uart_reset_i,
    input  logic [DIV_W-1:0] divisor_i,
    input  logic             tx_en_i,
    input  logic             rx_en_i,
    input  logic             tx_push_i,
    input  logic [7:0]       tx_data_i,
    input  logic             rx_pop_i,
    output logic [7:0]       rx_data_o,
    output logic             tx_full_o,
    output logic             tx_empty_o,
    output logic             rx_full_o,
    output logic             rx_empty_o,
    input  logic             uart_rx_i,
    output logic             uart_tx_o
`ifdef UART_RX_ERR_EN
    ,
    input  logic             rx_err_clr_i,
    output logic [1:0]       rx_err_o
`endif
);

    // ---------------------------------------------------------------- TX path
    logic                 tx_fifo_pop;
    logic [7:0]           tx_fifo_dat;
    serdes_state_t        tx_state_q, tx_state_d;
    logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_CNT_W-1:0] tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line_q, tx_line_d;

    uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .uart_clock_i (uart_clock_i),
        .uart_reset_i (uart_reset_i),
        .push         (tx_push_i),
        .wr_dat       (tx_data_i),
        .pop          (tx_fifo_pop),
        .rd_dat       (tx_fifo_dat),
        .full         (tx_full_o),
        .empty        (tx_empty_o)
    );

    assign uart_tx_o = tx_line_q;

    always_ff @(posedge uart_clock_i) begin
        if (uart_reset_i) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // tx_line_d is the value the line carries from the next cycle, so every
    // bit boundary drives the upcoming bit one cycle early into the register.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_line_d   = tx_line_q;
        tx_fifo_pop = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_line_d = 1'b1;
                if (tx_en_i && !tx_empty_o) begin
                    tx_fifo_pop = 1'b1;
                    tx_shift_d  = tx_fifo_dat;
                    tx_cnt_d    = divisor_i;
                    tx_state_d  = START;
                    tx_line_d   = 1'b0;
                end
            end
            START: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = divisor_i;
                    tx_bit_d   = '0;
                    tx_state_d = DATA;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = divisor_i;
                    tx_bit_d = tx_bit_q + BIT_CNT_W'(1);
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (tx_cnt_q == '0) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (tx_en_i && !tx_empty_o) begin
                        tx_fifo_pop = 1'b1;
                        tx_shift_d  = tx_fifo_dat;
                        tx_cnt_d    = divisor_i;
                        tx_state_d  = START;
                        tx_line_d   = 1'b0;
                    end else begin
                        tx_state_d = IDLE;
                        tx_line_d  = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - DIV_W'(1);
                end
            end
            default: begin
                tx_state_d = IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------- RX path
    logic                 rx_meta_q, rx_sync_q;
    logic                 rx_fifo_push;
    serdes_state_t        rx_state_q, rx_state_d;
    logic [DIV_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_CNT_W-1:0] rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

    uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .uart_clock_i (uart_clock_i),
        .uart_reset_i (uart_reset_i),
        .push         (rx_fifo_push),
        .wr_dat       (rx_shift_q),
        .pop          (rx_pop_i),
        .rd_dat       (rx_data_o),
        .full         (rx_full_o),
        .empty        (rx_empty_o)
    );

    always_ff @(posedge uart_clock_i) begin
        if (uart_reset_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= uart_rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Half-period load on the falling edge puts every later sample mid-bit.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_fifo_push = 1'b0;
        if (!rx_en_i) begin
            rx_state_d = IDLE;
        end else begin
            case (rx_state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        rx_cnt_d   = divisor_i >> 1;
                        rx_state_d = START;
                    end
                end
                START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_sync_q) begin
                            rx_state_d = IDLE;
                        end else begin
                            rx_cnt_d   = divisor_i;
                            rx_bit_d   = '0;
                            rx_state_d = DATA;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_cnt_d   = divisor_i;
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_bit_d   = rx_bit_q + BIT_CNT_W'(1);
                        if (rx_bit_q == LAST_BIT) rx_state_d = STOP;
                    end else begin
                        rx_cnt_d = rx_cnt_q - DIV_W'(1);
                    end
                end
                STOP: begin
                    if (rx_cnt_q == '0) begin
                        // A low stop bit is a framing error: the byte is discarded.
                        rx_fifo_push = rx_sync_q;
                        rx_state_d   = IDLE;
                    end else begin
                        rx_cnt_d = rx_cnt_q - DIV_W'(1);
                    end
                end
                default: rx_state_d = IDLE;
            endcase
        end
    end

`ifdef UART_RX_ERR_EN
    logic       framing_set;
    logic       overrun_set;
    logic [1:0] rx_err_q;

    assign framing_set = rx_en_i && (rx_state_q == STOP) && (rx_cnt_q == '0) && !rx_sync_q;
    // A pop in the same cycle frees a slot, so the byte is not lost then.
    assign overrun_set = rx_fifo_push && rx_full_o && !rx_pop_i;

    always_ff @(posedge uart_clock_i) begin
        if (uart_reset_i) begin
            rx_err_q <= 2'b00;
        end else begin
            rx_err_q <= (rx_err_clr_i ? 2'b00 : rx_err_q) | {overrun_set, framing_set};
        end
    end

    assign rx_err_o = rx_err_q;
`endif

endmodule
